traffic_light: RTL and testbench
================================

# traffic_light

Single-intersection traffic-light sequencer. It drives a 2-bit lamp code and commands an external down-counting phase timer: it loads a phase length and pulses a start strobe, then advances on the timer's done flag. The timer also supplies a square-wave flicker signal, which the sequencer uses to blink the green lamp before yellow. The block sits between the intersection's run/enable logic (`start`) and the shared timer block.

## Interface
Parameters:
- `RED_LEN`, default 20: red phase length in timer ticks, legal range 1..31.
- `GREEN_LEN`, default 16: steady-green length, 1..31.
- `FLICKER_LEN`, default 6: blinking-green length, 1..31.
- `YELLOW_LEN`, default 4: yellow length, 1..31.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1: run request; honoured only in IDLE.
- `t_flicker`  in  1: timer blink wave; used only in FLICKER.
- `t_done`  in  1: timer expiry flag for the current phase.
- `t_start`  out  1: one-cycle strobe; the timer loads `t_length` on this strobe.
- `t_length`  out  5: current phase length, held for the whole phase.
- `L_out`  out  2: lamp code: 00 OFF, 01 RED, 10 YELLOW, 11 GREEN.

## Operation
- States: IDLE, RED, GREEN, FLICKER, YELLOW.
- Normal cycle: IDLE → RED → GREEN → FLICKER → YELLOW → RED, repeating.
- IDLE:
  - `L_out`=00, `t_length`=0, `t_start`=0.
  - `start`=1 → RED.
  - `t_done` and `t_flicker` are ignored.
- Phase entry: on every state change into RED, GREEN, FLICKER or YELLOW:
  - `t_start`=1 for exactly one cycle.
  - `t_length` is set to that phase's LEN.
- RED, GREEN, YELLOW: `L_out` holds the phase colour until `t_done`.
- FLICKER: `L_out` = 11 when `t_flicker`=1, otherwise 00.
- Advancing: `t_done`=1 in a run state moves to the next state.
- Exception: `t_done` is ignored in the cycle where `t_start`=1, which guards against a stale done from the previous phase.
- Once running, `start` is ignored. The sequencer cycles until `reset` is asserted.
- Simultaneous events:
  - `start` and `t_done` together in IDLE → RED, same as `start` alone.
  - `reset`=0 dominates everything.
- Reset mid-phase: the next cycle is IDLE with all outputs at reset values. No further `t_start` pulse is produced.
- Elaboration fails if any LEN parameter is outside 1..31.

## Timing
- All outputs are registered. Reset values: `L_out`=00, `t_start`=0, `t_length`=0.
- Latency from `start` sampled high to `L_out`=01, `t_start`=1, `t_length`=RED_LEN: 1 cycle.
- Latency from `t_done` sampled high to the new colour plus its `t_start` pulse: 1 cycle.
- In FLICKER, `L_out` follows `t_flicker` with 1-cycle latency.
- Throughput: at most one phase change per cycle. The minimum phase duration is 2 cycles because of the `t_start` guard.

## Configuration
- `TRAFFIC_LIGHT_FLICKER_EN` defined:
  - FLICKER state present; GREEN → FLICKER → YELLOW.
- `TRAFFIC_LIGHT_FLICKER_EN` undefined:
  - FLICKER state removed; GREEN → YELLOW on `t_done`.
  - `t_flicker` is unused.
  - `FLICKER_LEN` is unused and not range-checked.

## Structure
- Package `traffic_light_pkg` holds:
  - the state enum (`tl_state_t`);
  - the lamp-code constants (`LAMP_OFF`, `LAMP_RED`, `LAMP_YELLOW`, `LAMP_GREEN`);
  - the 5-bit length typedef.
- No sub-module: a single FSM with registered outputs. The timer stays external.

## Test plan
- Reset: hold `reset`=0 for 2 cycles → `L_out`=00, `t_start`=0, `t_length`=0. With `start`=0 afterwards, the outputs stay at those values.
- Start: 1-cycle `start` pulse → next cycle `L_out`=01, `t_start`=1 for one cycle, `t_length`=20. A second `start` during RED has no effect.
- Full cycle, macro defined, timer model returning `t_done` after LEN ticks:
  - sequence 01 → 11 → blinking 11/00 → 10 → 01;
  - `t_length` 20 → 16 → 6 → 4 → 20;
  - exactly one `t_start` per phase.
- Flicker: in FLICKER, toggle `t_flicker` every 2 cycles → `L_out` alternates 11/00, lagging `t_flicker` by 1 cycle.
- Guard and stale done: hold `t_done`=1 continuously from the start pulse → the state advances every 2 cycles, never every cycle.
- Mid-phase reset during GREEN → next cycle `L_out`=00, `t_length`=0. No `t_start` until a new `start`; the restart begins in RED.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// ============================================================================
// Module : traffic_light_pkg
// Brief  : State, lamp-code and phase-length types for the traffic_light FSM.
//          The FLICKER state exists only with TRAFFIC_LIGHT_FLICKER_EN defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_light_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RED     = 3'd1,
        ST_GREEN   = 3'd2,
`ifdef TRAFFIC_LIGHT_FLICKER_EN
        ST_FLICKER = 3'd3,
`endif
        ST_YELLOW  = 3'd4
    } tl_state_t;

    localparam logic [1:0] LAMP_OFF    = 2'b00;
    localparam logic [1:0] LAMP_RED    = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_GREEN  = 2'b11;

    typedef logic [4:0] tl_len_t;

endpackage

`default_nettype wire

// File: rtl/traffic_light.sv
// ============================================================================
// Module : traffic_light
// Brief  : Single-intersection light sequencer driving an external phase
//          timer. Optional blinking-green phase: TRAFFIC_LIGHT_FLICKER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_light
    import traffic_light_pkg::*;
#(
    parameter int RED_LEN     = 20,
    parameter int GREEN_LEN   = 16,
    parameter int FLICKER_LEN = 6,
    parameter int YELLOW_LEN  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       t_flicker,
    input  logic       t_done,
    output logic       t_start,
    output logic [4:0] t_length,
    output logic [1:0] L_out
);

    if (RED_LEN < 1 || RED_LEN > 31) begin : g_bad_red_len
        $error("traffic_light: RED_LEN must be in 1..31");
    end
    if (GREEN_LEN < 1 || GREEN_LEN > 31) begin : g_bad_green_len
        $error("traffic_light: GREEN_LEN must be in 1..31");
    end
    if (YELLOW_LEN < 1 || YELLOW_LEN > 31) begin : g_bad_yellow_len
        $error("traffic_light: YELLOW_LEN must be in 1..31");
    end
`ifdef TRAFFIC_LIGHT_FLICKER_EN
    if (FLICKER_LEN < 1 || FLICKER_LEN > 31) begin : g_bad_flicker_len
        $error("traffic_light: FLICKER_LEN must be in 1..31");
    end
`else
    logic w_unused;
    assign w_unused = ^{t_flicker, tl_len_t'(FLICKER_LEN)};
`endif

    tl_state_t  r_state;
    tl_state_t  w_state_nxt;
    logic       r_t_start;
    tl_len_t    r_t_length;
    logic [1:0] r_lamp;

    logic       w_advance;
    logic       w_t_start_nxt;
    tl_len_t    w_t_length_nxt;
    logic [1:0] w_lamp_nxt;

    // A done seen while the start strobe is out belongs to the previous phase.
    assign w_advance = t_done && !r_t_start;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start)     w_state_nxt = ST_RED;
            ST_RED:     if (w_advance) w_state_nxt = ST_GREEN;
`ifdef TRAFFIC_LIGHT_FLICKER_EN
            ST_GREEN:   if (w_advance) w_state_nxt = ST_FLICKER;
            ST_FLICKER: if (w_advance) w_state_nxt = ST_YELLOW;
`else
            ST_GREEN:   if (w_advance) w_state_nxt = ST_YELLOW;
`endif
            ST_YELLOW:  if (w_advance) w_state_nxt = ST_RED;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_t_start_nxt  = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);
        w_t_length_nxt = '0;
        w_lamp_nxt     = LAMP_OFF;
        case (w_state_nxt)
            ST_RED: begin
                w_t_length_nxt = tl_len_t'(RED_LEN);
                w_lamp_nxt     = LAMP_RED;
            end
            ST_GREEN: begin
                w_t_length_nxt = tl_len_t'(GREEN_LEN);
                w_lamp_nxt     = LAMP_GREEN;
            end
`ifdef TRAFFIC_LIGHT_FLICKER_EN
            ST_FLICKER: begin
                w_t_length_nxt = tl_len_t'(FLICKER_LEN);
                w_lamp_nxt     = t_flicker ? LAMP_GREEN : LAMP_OFF;
            end
`endif
            ST_YELLOW: begin
                w_t_length_nxt = tl_len_t'(YELLOW_LEN);
                w_lamp_nxt     = LAMP_YELLOW;
            end
            default: begin
                w_t_length_nxt = '0;
                w_lamp_nxt     = LAMP_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_t_start  <= 1'b0;
            r_t_length <= '0;
            r_lamp     <= LAMP_OFF;
        end else begin
            r_state    <= w_state_nxt;
            r_t_start  <= w_t_start_nxt;
            r_t_length <= w_t_length_nxt;
            r_lamp     <= w_lamp_nxt;
        end
    end

    assign t_start  = r_t_start;
    assign t_length = r_t_length;
    assign L_out    = r_lamp;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light.sv
// ============================================================================
// Module : tb_traffic_light
// Brief  : Scoreboard bench for traffic_light; follows TRAFFIC_LIGHT_FLICKER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_light;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       t_flicker = 1'b0;
    logic       t_done = 1'b0;
    logic       t_start;
    logic [4:0] t_length;
    logic [1:0] L_out;

    localparam logic [1:0] c_off = 2'b00;
    localparam logic [1:0] c_red = 2'b01;
    localparam logic [1:0] c_yel = 2'b10;
    localparam logic [1:0] c_grn = 2'b11;

    traffic_light #(
        .RED_LEN     (20),
        .GREEN_LEN   (16),
        .FLICKER_LEN (6),
        .YELLOW_LEN  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .t_flicker (t_flicker),
        .t_done    (t_done),
        .t_start   (t_start),
        .t_length  (t_length),
        .L_out     (L_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] lamp;
        logic       ts;
        logic [4:0] len;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expectation is consumed per rising edge, sampled 1 time unit later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({L_out, t_start, t_length} !== {e.lamp, e.ts, e.len}) begin
                errors++;
                $display("FAIL %s: got L_out=%b t_start=%b t_length=%0d, want L_out=%b t_start=%b t_length=%0d",
                         e.tag, L_out, t_start, t_length, e.lamp, e.ts, e.len);
            end
        end
    end

    task automatic step(input logic rn, input logic st, input logic dn, input logic fl,
                        input logic [1:0] lamp, input logic ts, input logic [4:0] len,
                        input string tag);
        exp_t e;
        reset     = rn;
        start     = st;
        t_done    = dn;
        t_flicker = fl;
        e.lamp = lamp;
        e.ts   = ts;
        e.len  = len;
        e.tag  = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input logic fl, input logic [1:0] lamp,
                        input logic [4:0] len, input string tag);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 1'b0, fl, lamp, 1'b0, len, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Reset and idle behaviour
        step(1'b0, 1'b0, 1'b0, 1'b0, c_off, 1'b0, 5'd0, "reset0");
        step(1'b0, 1'b1, 1'b1, 1'b1, c_off, 1'b0, 5'd0, "reset_dominates");
        hold(2, 1'b0, c_off, 5'd0, "idle");
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b0, 1'b1, 1'b1, c_off, 1'b0, 5'd0, "idle_ignores_done");

        // Start, then a full cycle with LEN-cycle phases
        step(1'b1, 1'b1, 1'b0, 1'b0, c_red, 1'b1, 5'd20, "start");
        step(1'b1, 1'b1, 1'b0, 1'b0, c_red, 1'b0, 5'd20, "start_in_red");
        hold(18, 1'b0, c_red, 5'd20, "red");
        step(1'b1, 1'b0, 1'b1, 1'b0, c_grn, 1'b1, 5'd16, "red_to_green");
        hold(15, 1'b1, c_grn, 5'd16, "green");
`ifdef TRAFFIC_LIGHT_FLICKER_EN
        step(1'b1, 1'b0, 1'b1, 1'b0, c_off, 1'b1, 5'd6, "green_to_flicker");
        step(1'b1, 1'b0, 1'b0, 1'b1, c_grn, 1'b0, 5'd6, "flicker_on0");
        step(1'b1, 1'b0, 1'b0, 1'b1, c_grn, 1'b0, 5'd6, "flicker_on1");
        step(1'b1, 1'b0, 1'b0, 1'b0, c_off, 1'b0, 5'd6, "flicker_off0");
        step(1'b1, 1'b0, 1'b0, 1'b0, c_off, 1'b0, 5'd6, "flicker_off1");
        step(1'b1, 1'b0, 1'b0, 1'b1, c_grn, 1'b0, 5'd6, "flicker_on2");
        step(1'b1, 1'b0, 1'b1, 1'b1, c_yel, 1'b1, 5'd4, "flicker_to_yellow");
`else
        step(1'b1, 1'b0, 1'b1, 1'b1, c_yel, 1'b1, 5'd4, "green_to_yellow");
`endif
        hold(3, 1'b1, c_yel, 5'd4, "yellow");
        step(1'b1, 1'b0, 1'b1, 1'b0, c_red, 1'b1, 5'd20, "yellow_to_red");
        hold(2, 1'b0, c_red, 5'd20, "red_again");

        // Continuous done from the start pulse: one advance per two cycles
        step(1'b0, 1'b0, 1'b0, 1'b0, c_off, 1'b0, 5'd0, "reset_before_stale");
        step(1'b1, 1'b1, 1'b1, 1'b0, c_red, 1'b1, 5'd20, "start_with_done");
        step(1'b1, 1'b0, 1'b1, 1'b0, c_red, 1'b0, 5'd20, "guard_red");
        step(1'b1, 1'b0, 1'b1, 1'b0, c_grn, 1'b1, 5'd16, "stale_green");
        step(1'b1, 1'b0, 1'b1, 1'b0, c_grn, 1'b0, 5'd16, "guard_green");
`ifdef TRAFFIC_LIGHT_FLICKER_EN
        step(1'b1, 1'b0, 1'b1, 1'b0, c_off, 1'b1, 5'd6, "stale_flicker");
        step(1'b1, 1'b0, 1'b1, 1'b1, c_grn, 1'b0, 5'd6, "guard_flicker");
`endif
        step(1'b1, 1'b0, 1'b1, 1'b0, c_yel, 1'b1, 5'd4, "stale_yellow");
        step(1'b1, 1'b0, 1'b1, 1'b0, c_yel, 1'b0, 5'd4, "guard_yellow");
        step(1'b1, 1'b0, 1'b1, 1'b0, c_red, 1'b1, 5'd20, "stale_red");
        step(1'b1, 1'b0, 1'b1, 1'b0, c_red, 1'b0, 5'd20, "guard_red2");

        // Reset in the middle of GREEN, then restart
        step(1'b1, 1'b0, 1'b1, 1'b0, c_grn, 1'b1, 5'd16, "to_green");
        hold(2, 1'b0, c_grn, 5'd16, "green_pre_reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, c_off, 1'b0, 5'd0, "mid_reset");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 1'b1, c_off, 1'b0, 5'd0, "post_reset_idle");
        step(1'b1, 1'b1, 1'b0, 1'b0, c_red, 1'b1, 5'd20, "restart");
        step(1'b1, 1'b0, 1'b0, 1'b0, c_red, 1'b0, 5'd20, "restart_hold");

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
